// File: rtl/arp_sequencer.sv
// Arpeggiator step sequencer: a small writable table of pitch half-periods played
// at a fixed tempo in up, down, up-down or hold order, one strobe per step.
module arp_sequencer #(
    parameter int DEPTH      = 8,
    parameter int PERIOD_W   = 20,
    parameter int STEP_TICKS = 10000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [PERIOD_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic [1:0]                 mode,
    input  logic                       run,
    output logic [PERIOD_W-1:0]        period,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       step_strobe,
    output logic                       note_on
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UD   = 2'b10;

    typedef enum logic {IDLE, PLAY} state_t;

    logic [PERIOD_W-1:0] table_q [DEPTH];
    logic [PERIOD_W-1:0] table_d [DEPTH];

    state_t              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                dir_q, dir_d;          // 0 = ascending
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                strobe_q, strobe_d;
    logic                note_q, note_d;

    logic [LW-1:0]       len_eff;
    logic [AW-1:0]       last_idx;
    logic                over;
    logic [AW-1:0]       adv_idx;
    logic                adv_dir;
    logic [AW-1:0]       load_idx;
    logic                load;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
        assign table_d[gi] = (wr_en && wr_addr == AW'(gi)) ? wr_data : table_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else begin
            table_q <= table_d;
        end
    end

    always_comb begin
        if (len == '0)                len_eff = LW'(1);
        else if (len > LW'(DEPTH))    len_eff = LW'(DEPTH);
        else                          len_eff = len;
        last_idx = AW'(len_eff - LW'(1));
        over     = {1'b0, idx_q} >= len_eff;
    end

    // Next index at a step boundary; an out-of-range index restarts the pattern.
    always_comb begin
        adv_idx = idx_q;
        adv_dir = dir_q;
        case (mode)
            MODE_UP:   adv_idx = (over || idx_q == last_idx) ? '0 : idx_q + AW'(1);
            MODE_DOWN: adv_idx = (over || idx_q == '0) ? last_idx : idx_q - AW'(1);
            MODE_UD: begin
                if (over || len_eff == LW'(1)) begin
                    adv_idx = '0;
                    adv_dir = 1'b0;
                end else if (!dir_q) begin
                    if (idx_q == last_idx) begin
                        adv_idx = idx_q - AW'(1);
                        adv_dir = 1'b1;
                    end else begin
                        adv_idx = idx_q + AW'(1);
                    end
                end else begin
                    if (idx_q == '0) begin
                        adv_idx = AW'(1);
                        adv_dir = 1'b0;
                    end else begin
                        adv_idx = idx_q - AW'(1);
                    end
                end
            end
            default:   adv_idx = over ? '0 : idx_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        idx_d    = idx_q;
        dir_d    = dir_q;
        period_d = period_q;
        strobe_d = 1'b0;
        note_d   = note_q;
        load     = 1'b0;
        load_idx = adv_idx;
        case (state_q)
            IDLE: begin
                tick_d   = '0;
                dir_d    = 1'b0;
                idx_d    = '0;
                period_d = '0;
                note_d   = 1'b0;
                if (run) begin
                    state_d  = PLAY;
                    load     = 1'b1;
                    load_idx = (mode == MODE_DOWN) ? last_idx : '0;
                end
            end
            default: begin
                if (!run) begin
                    state_d  = IDLE;
                    tick_d   = '0;
                    dir_d    = 1'b0;
                    idx_d    = '0;
                    period_d = '0;
                    note_d   = 1'b0;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    dir_d  = adv_dir;
                    load   = 1'b1;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
        endcase
        // Reads the pre-edge table, so a same-cycle write to this entry loads the old value.
        if (load) begin
            idx_d    = load_idx;
            period_d = table_q[load_idx];
            strobe_d = 1'b1;
            note_d   = table_q[load_idx] != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            idx_q    <= '0;
            dir_q    <= 1'b0;
            period_q <= '0;
            strobe_q <= 1'b0;
            note_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            strobe_q <= strobe_d;
            note_q   <= note_d;
        end
    end

    assign period      = period_q;
    assign step_idx    = idx_q;
    assign step_strobe = strobe_q;
    assign note_on     = note_q;
endmodule

// File: tb/tb_arp_sequencer.sv
// Bench for arp_sequencer: per-cycle comparison against a pattern-level model,
// plus literal step expectations along a directed scenario.
module tb_arp_sequencer;
    localparam int DEPTH = 8;
    localparam int PW    = 20;
    localparam int ST    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [PW-1:0] wr_data = '0;
    logic [3:0]    len = 4'd4;
    logic [1:0]    mode = 2'b00;
    logic          run = 1'b0;
    logic [PW-1:0] period;
    logic [2:0]    step_idx;
    logic          step_strobe;
    logic          note_on;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    arp_sequencer #(.DEPTH(DEPTH), .PERIOD_W(PW), .STEP_TICKS(ST)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .mode(mode), .run(run), .period(period), .step_idx(step_idx),
        .step_strobe(step_strobe), .note_on(note_on)
    );

    always #5 clk = ~clk;

    // Model: pattern position and cycles-since-start, not the DUT's counters.
    int m_tbl [DEPTH];
    bit m_play = 0;
    int m_age, m_idx, m_p;
    int e_period = 0, e_idx = 0;
    bit e_str = 0, e_note = 0;

    always @(posedge clk) begin
        int L;
        bit ld;
        ld = 0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_tbl[i] = 0;
            m_play = 0; e_period = 0; e_idx = 0; e_str = 0; e_note = 0;
        end else begin
            L = (len == 0) ? 1 : ((int'(len) > DEPTH) ? DEPTH : int'(len));
            e_str = 0;
            if (!m_play) begin
                if (run) begin
                    m_play = 1; m_age = 0; m_p = 0;
                    m_idx = (mode == 2'b01) ? L - 1 : 0;
                    ld = 1;
                end
            end else if (!run) begin
                m_play = 0; e_period = 0; e_idx = 0; e_note = 0;
            end else begin
                m_age++;
                if (m_age % ST == 0) begin
                    ld = 1;
                    case (mode)
                        2'b00: m_idx = (m_idx + 1 >= L) ? 0 : m_idx + 1;
                        2'b01: m_idx = (m_idx == 0 || m_idx >= L) ? L - 1 : m_idx - 1;
                        2'b10: begin
                            if (L == 1) m_idx = 0;
                            else begin
                                m_p = (m_idx >= L) ? 0 : (m_p + 1) % (2 * L - 2);
                                m_idx = (m_p < L) ? m_p : 2 * L - 2 - m_p;
                            end
                        end
                        default: if (m_idx >= L) m_idx = 0;
                    endcase
                end
            end
            if (ld) begin
                e_period = m_tbl[m_idx]; e_idx = m_idx; e_str = 1; e_note = (e_period != 0);
            end
            if (wr_en) m_tbl[wr_addr] = int'(wr_data);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model.period", int'(period), e_period);
            chk("model.step_idx", int'(step_idx), e_idx);
            chk("model.step_strobe", int'(step_strobe), int'(e_str));
            chk("model.note_on", int'(note_on), int'(e_note));
        end
    end

    task automatic wait_strobe(input int ei, input int ep, input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_strobe && n < 12);
        chk({nm, ".strobe"}, int'(step_strobe), 1);
        chk({nm, ".idx"}, int'(step_idx), ei);
        chk({nm, ".period"}, int'(period), ep);
        $display("step %s: idx=%0d period=%0d note_on=%0d after %0d cycles", nm, step_idx, period, note_on, n);
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = PW'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    int pv [4];
    int n, cnt;
    int ud [8];
    int dn [4];

    initial begin
        pv[0] = 382233; pv[1] = 340529; pv[2] = 286352; pv[3] = 227272;
        ud[0] = 0; ud[1] = 1; ud[2] = 2; ud[3] = 3; ud[4] = 2; ud[5] = 1; ud[6] = 0; ud[7] = 1;
        dn[0] = 2; dn[1] = 1; dn[2] = 0; dn[3] = 2;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        started = 1;
        chk("reset.period", int'(period), 0);
        chk("reset.step_idx", int'(step_idx), 0);
        chk("reset.note_on", int'(note_on), 0);
        chk("reset.strobe", int'(step_strobe), 0);

        for (int i = 0; i < 4; i++) wr(i, pv[i]);
        mode = 2'b00; len = 4'd4; run = 1'b1;
        wait_strobe(0, 382233, "up0", n);
        chk("up.first_latency", n, 1);
        for (int i = 1; i <= 4; i++) begin
            wait_strobe(i % 4, pv[i % 4], $sformatf("up%0d", i), n);
            chk("up.spacing", n, ST);
        end

        run = 1'b0; @(negedge clk);
        mode = 2'b10; run = 1'b1;
        for (int i = 0; i < 8; i++) wait_strobe(ud[i], pv[ud[i]], $sformatf("ud%0d", i), n);
        run = 1'b0; @(negedge clk);
        len = 4'd1; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_strobe(0, 382233, "ud_len1", n);
            if (i > 0) chk("ud_len1.spacing", n, ST);
        end

        run = 1'b0; @(negedge clk);
        mode = 2'b01; len = 4'd0; run = 1'b1;
        for (int i = 0; i < 3; i++) wait_strobe(0, 382233, "down_len0", n);
        run = 1'b0; @(negedge clk);
        len = 4'd3; run = 1'b1;
        for (int i = 0; i < 4; i++) wait_strobe(dn[i], pv[dn[i]], $sformatf("down%0d", i), n);
        len = 4'd2;
        wait_strobe(1, 340529, "down_shrink", n);
        wait_strobe(0, 382233, "down_shrink_next", n);

        run = 1'b0; @(negedge clk);
        mode = 2'b00; len = 4'd4;
        wr(2, 0);
        run = 1'b1;
        wait_strobe(0, 382233, "rest0", n);
        wait_strobe(1, 340529, "rest1", n);
        chk("rest1.note_on", int'(note_on), 1);
        wr(1, 191116);
        chk("midstep_write.period", int'(period), 340529);
        wait_strobe(2, 0, "rest2", n);
        chk("rest2.note_on", int'(note_on), 0);
        wait_strobe(3, 227272, "rest3", n);
        chk("rest3.note_on", int'(note_on), 1);
        wait_strobe(0, 382233, "rest4", n);
        wait_strobe(1, 191116, "rewritten1", n);
        repeat (3) @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = PW'(111111);
        wait_strobe(2, 0, "collision", n);
        wr_en = 1'b0;
        chk("collision.latency", n, 1);
        wait_strobe(3, 227272, "after_coll3", n);
        wait_strobe(0, 382233, "after_coll0", n);
        wait_strobe(1, 191116, "after_coll1", n);
        wait_strobe(2, 111111, "after_coll2", n);

        repeat (2) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk("stop.note_on", int'(note_on), 0);
        chk("stop.period", int'(period), 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (step_strobe) cnt++;
        end
        chk("stop.no_strobes", cnt, 0);
        run = 1'b1;
        wait_strobe(0, 382233, "restart", n);
        chk("restart.latency", n, 1);
        wait_strobe(1, 191116, "restart1", n);
        chk("restart.full_step", n, ST);

        @(negedge clk);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = PW'(5);
        @(negedge clk);
        chk("rst.period", int'(period), 0);
        chk("rst.step_idx", int'(step_idx), 0);
        chk("rst.strobe", int'(step_strobe), 0);
        chk("rst.note_on", int'(note_on), 0);
        rst = 1'b0; wr_en = 1'b0; run = 1'b0; len = 4'd8; mode = 2'b00;
        @(negedge clk);
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_strobe(i, 0, $sformatf("cleared%0d", i), n);
            chk("cleared.note_on", int'(note_on), 0);
        end
        run = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
